// File: rtl/dmem_wait_responder.sv
// dmem_wait_responder
//   Data-memory responder with a fixed access latency. Accepts one load or
//   store request at a time, counts out LATENCY cycles, then issues a single
//   cycle response (load data or store complete). Used in place of the
//   zero-wait data memory so the Memory-stage stall path gets exercised.
//
// Handshake: a request (storeValid / loadValid) is sampled only while the
//   block is idle (busy=0). The initiator holds the request until it sees
//   the one-cycle response; a request still high in the cycle after the
//   response is taken as a new request. Store wins over a simultaneous load.
//
// Ports:
//   clock, reset     - clock; asynchronous active-high reset
//   address          - byte address, word index = address[31:2]
//   storeData        - lane-aligned write data
//   byteEnable       - per-byte-lane write enable
//   storeValid       - store request
//   loadValid        - load request
//   loadData         - word read for the last load response (held)
//   loadDataValid    - one-cycle load response
//   storeComplete    - one-cycle store response
//   accessFault      - one-cycle pulse with the response when out of range
//   busy             - request accepted but not yet answered
//   o_dbg_state      - FSM state (0 = IDLE, 1 = WAIT)
module dmem_wait_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  input  logic [3:0]  byteEnable,
  input  logic        storeValid,
  input  logic        loadValid,
  output logic [31:0] loadData,
  output logic        loadDataValid,
  output logic        storeComplete,
  output logic        accessFault,
  output logic        busy,
  output logic        o_dbg_state
);

  localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("dmem_wait_responder: LATENCY must be in 1..15");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic [3:0]  w_next_cnt;
  logic        w_accept;

  logic [29:0] r_word_idx;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_is_store;
  logic [31:0] r_load_data;

  logic [31:0] r_mem [0:DEPTH_WORDS-1];

  logic            w_resp;
  logic            w_fault;
  logic [IDXW-1:0] w_mem_idx;
  logic [31:0]     w_rd_word;
  logic            w_unused;

  // Byte-offset bits carry no meaning for a word memory.
  assign w_unused = ^address[1:0];

  // Response cycle: in WAIT with the counter already at zero on entry.
  assign w_resp    = (r_state == ST_WAIT) && (r_cnt == 4'd0);
  assign w_fault   = ({2'b00, r_word_idx} >= 32'(DEPTH_WORDS));
  assign w_mem_idx = r_word_idx[IDXW-1:0];
  assign w_rd_word = w_fault ? 32'd0 : r_mem[w_mem_idx];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (storeValid || loadValid) begin
          w_accept     = 1'b1;
          w_next_state = ST_WAIT;
          w_next_cnt   = 4'(LATENCY - 1);
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ---------------- Request latch and held load data ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_word_idx  <= 30'd0;
      r_wdata     <= 32'd0;
      r_be        <= 4'd0;
      r_is_store  <= 1'b0;
      r_load_data <= 32'd0;
    end else begin
      if (w_accept) begin
        r_word_idx <= address[31:2];
        r_wdata    <= storeData;
        r_be       <= byteEnable;
        r_is_store <= storeValid;
      end
      if (w_resp && !r_is_store) begin
        r_load_data <= w_rd_word;
      end
    end
  end

  // ---------------- Backing array (not reset) ----------------
  // Reset forces IDLE, so an aborted store never reaches this write.
  always_ff @(posedge clock) begin
    if (w_resp && r_is_store && !w_fault) begin
      for (int n = 0; n < 4; n++) begin
        if (r_be[n]) begin
          r_mem[w_mem_idx][8*n +: 8] <= r_wdata[8*n +: 8];
        end
      end
    end
  end

  // ---------------- Outputs ----------------
  // The read word is presented during the response cycle itself and is
  // captured into r_load_data so it holds until the next load response.
  assign loadDataValid = w_resp && !r_is_store;
  assign storeComplete = w_resp && r_is_store;
  assign accessFault   = w_resp && w_fault;
  assign busy          = (r_state == ST_WAIT);
  assign loadData      = loadDataValid ? w_rd_word : r_load_data;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench for dmem_wait_responder: one LATENCY=3 instance for the
// main scenarios and one LATENCY=1 instance for the back-to-back stream.
module tb_dmem_wait_responder;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // LATENCY=3 instance
  logic [31:0] address = '0, storeData = '0;
  logic [3:0]  byteEnable = '0;
  logic        storeValid = 1'b0, loadValid = 1'b0;
  logic [31:0] loadData;
  logic        loadDataValid, storeComplete, accessFault, busy, dbg_state;

  // LATENCY=1 instance
  logic [31:0] address1 = '0, storeData1 = '0;
  logic [3:0]  byteEnable1 = '0;
  logic        storeValid1 = 1'b0, loadValid1 = 1'b0;
  logic [31:0] loadData1;
  logic        loadDataValid1, storeComplete1, accessFault1, busy1, dbg_state1;

  dmem_wait_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) dut (
    .clock(clock), .reset(reset), .address(address), .storeData(storeData),
    .byteEnable(byteEnable), .storeValid(storeValid), .loadValid(loadValid),
    .loadData(loadData), .loadDataValid(loadDataValid),
    .storeComplete(storeComplete), .accessFault(accessFault), .busy(busy),
    .o_dbg_state(dbg_state)
  );

  dmem_wait_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .address(address1), .storeData(storeData1),
    .byteEnable(byteEnable1), .storeValid(storeValid1), .loadValid(loadValid1),
    .loadData(loadData1), .loadDataValid(loadDataValid1),
    .storeComplete(storeComplete1), .accessFault(accessFault1), .busy(busy1),
    .o_dbg_state(dbg_state1)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Outputs depend only on registers, so sampling 1ns after the edge is safe.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one request on the LATENCY=3 instance from an idle cycle (cycle 0),
  // drop it after the response is seen, and watch 8 cycles in total.
  task automatic run_txn(input logic st, input logic ld, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be,
                         output int sc_n, output int ld_n, output int busy_n,
                         output int resp_cyc, output logic [31:0] rdata,
                         output logic fault);
    sc_n = 0; ld_n = 0; busy_n = 0; resp_cyc = -1; rdata = '0; fault = 1'b0;
    address = addr; storeData = data; byteEnable = be;
    storeValid = st; loadValid = ld;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (busy) busy_n++;
      if (storeComplete) sc_n++;
      if (loadDataValid) ld_n++;
      if ((storeComplete || loadDataValid) && resp_cyc < 0) begin
        resp_cyc   = t;
        rdata      = loadData;
        fault      = accessFault;
        storeValid = 1'b0;
        loadValid  = 1'b0;
      end
    end
    storeValid = 1'b0;
    loadValid  = 1'b0;
  endtask

  int          sc_n, ld_n, busy_n, resp_cyc;
  logic [31:0] rdata;
  logic        fault;
  logic [9:0]  pat;
  int          bad_data1;

  initial begin
    // ---------------- reset state ----------------
    dut.r_mem[0]   = 32'h0BADF00D;
    dut.r_mem[4]   = 32'hDEADBEEF;
    dut.r_mem[8]   = 32'h11223344;
    dut.r_mem[12]  = 32'hCAFE0030;
    dut1.r_mem[1]  = 32'h12345678;
    tick(); tick();
    chk("rst_loadData", loadData, 32'd0);
    chk("rst_outputs", {28'd0, loadDataValid, storeComplete, accessFault, busy}, 32'd0);
    chk("rst_state", {31'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    tick();

    // ---------------- load word 4 ----------------
    run_txn(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, sc_n, ld_n, busy_n, resp_cyc, rdata, fault);
    chk("ld10_resp_cycle", resp_cyc, 3);
    chk("ld10_pulses", {ld_n[15:0], sc_n[15:0]}, {16'd1, 16'd0});
    chk("ld10_busy_cycles", busy_n, 3);
    chk("ld10_data", rdata, 32'hDEADBEEF);
    chk("ld10_fault", {31'd0, fault}, 32'd0);
    chk("ld10_held", loadData, 32'hDEADBEEF);

    // ---------------- partial store, then load ----------------
    run_txn(1'b1, 1'b0, 32'h10, 32'h000000AA, 4'b0001, sc_n, ld_n, busy_n, resp_cyc, rdata, fault);
    chk("st10_pulses", {ld_n[15:0], sc_n[15:0]}, {16'd0, 16'd1});
    chk("st10_resp_cycle", resp_cyc, 3);
    chk("st10_loaddata_kept", rdata, 32'hDEADBEEF);
    run_txn(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, sc_n, ld_n, busy_n, resp_cyc, rdata, fault);
    chk("ld10_after_st", rdata, 32'hDEADBEAA);

    // ---------------- store + load together ----------------
    run_txn(1'b1, 1'b1, 32'h20, 32'h55667788, 4'b1111, sc_n, ld_n, busy_n, resp_cyc, rdata, fault);
    chk("both20_pulses", {ld_n[15:0], sc_n[15:0]}, {16'd0, 16'd1});
    run_txn(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, sc_n, ld_n, busy_n, resp_cyc, rdata, fault);
    chk("ld20_after_both", rdata, 32'h55667788);

    // ---------------- store with no lanes enabled ----------------
    run_txn(1'b1, 1'b0, 32'h20, 32'hFFFFFFFF, 4'b0000, sc_n, ld_n, busy_n, resp_cyc, rdata, fault);
    chk("be0_pulses", {ld_n[15:0], sc_n[15:0]}, {16'd0, 16'd1});
    run_txn(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, sc_n, ld_n, busy_n, resp_cyc, rdata, fault);
    chk("be0_no_change", rdata, 32'h55667788);

    // ---------------- out of range ----------------
    run_txn(1'b0, 1'b1, 32'h1000, 32'h0, 4'h0, sc_n, ld_n, busy_n, resp_cyc, rdata, fault);
    chk("oor_ld_pulses", {ld_n[15:0], sc_n[15:0]}, {16'd1, 16'd0});
    chk("oor_ld_fault", {31'd0, fault}, 32'd1);
    chk("oor_ld_data", rdata, 32'd0);
    run_txn(1'b1, 1'b0, 32'h1000, 32'hFFFFFFFF, 4'b1111, sc_n, ld_n, busy_n, resp_cyc, rdata, fault);
    chk("oor_st_pulses", {ld_n[15:0], sc_n[15:0]}, {16'd0, 16'd1});
    chk("oor_st_fault", {31'd0, fault}, 32'd1);
    run_txn(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, sc_n, ld_n, busy_n, resp_cyc, rdata, fault);
    chk("oor_st_no_alias", rdata, 32'h0BADF00D);
    chk("inrange_fault", {31'd0, fault}, 32'd0);

    // ---------------- reset mid-WAIT aborts a store ----------------
    address = 32'h30; storeData = 32'h0; byteEnable = 4'b1111; storeValid = 1'b1;
    tick();
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    storeValid = 1'b0;
    chk("abort_outputs", {28'd0, loadDataValid, storeComplete, accessFault, busy}, 32'd0);
    chk("abort_loadData", loadData, 32'd0);
    sc_n = 0;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (storeComplete) sc_n++;
    end
    reset = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (storeComplete) sc_n++;
    end
    chk("abort_no_complete", sc_n, 0);
    run_txn(1'b0, 1'b1, 32'h30, 32'h0, 4'h0, sc_n, ld_n, busy_n, resp_cyc, rdata, fault);
    chk("abort_no_write", rdata, 32'hCAFE0030);

    // ---------------- LATENCY=1 held load stream ----------------
    address1 = 32'h4; loadValid1 = 1'b1;
    pat = '0; bad_data1 = 0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      pat[t-1] = loadDataValid1;
      if (loadDataValid1 && loadData1 !== 32'h12345678) bad_data1++;
    end
    loadValid1 = 1'b0;
    chk("lat1_pattern", {22'd0, pat}, {22'd0, 10'b01_0101_0101});
    chk("lat1_data", bad_data1, 0);
    tick();
    chk("lat1_idle", {31'd0, busy1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
